// File: rtl/axi_stream_remove_header.sv
// axi_stream_remove_header
//   Strips a per-packet number of leading bytes (byte_remove_cnt) from an
//   AXI-Stream packet and re-packs the remaining bytes onto full beats.
//   Lane DATA_BYTE_WD-1 (data[DATA_WD-1 -: 8]) is the first byte on the wire,
//   and keep is contiguous from the MSB.
// Ports
//   clk, rst_n                        clock, synchronous active-low reset
//   valid_in/data_in/keep_in/last_in  input stream, ready_in back-pressure
//   valid_out/data_out/keep_out/last_out output stream, ready_out from sink
//   valid_remove/byte_remove_cnt      per-packet strip command, ready_remove
module axi_stream_remove_header #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  input  logic                    valid_remove,
  input  logic [BYTE_CNT_WD-1:0]  byte_remove_cnt,
  output logic                    ready_remove
);

  typedef enum logic [1:0] {S_IDLE, S_FIRST, S_STREAM, S_FLUSH} state_t;

  state_t                 r_state;
  logic [DATA_WD-1:0]     r_hold;
  logic [BYTE_CNT_WD:0]   r_hold_bytes;
  logic [BYTE_CNT_WD-1:0] r_n;

  logic [BYTE_CNT_WD:0]   w_v;
  logic [DATA_WD-1:0]     w_din;
  logic [DATA_WD-1:0]     w_shl;
  logic [DATA_WD-1:0]     w_shr;
  logic                   w_v_gt_n;
  logic [DATA_WD-1:0]     w_data;
  int unsigned            w_shl_amt;
  int unsigned            w_shr_amt;
  int unsigned            w_tail_cnt;

  function automatic logic [DATA_BYTE_WD-1:0] top_keep(input int unsigned cnt);
    top_keep = ~({DATA_BYTE_WD{1'b1}} >> cnt);
  endfunction

  function automatic logic [DATA_WD-1:0] lane_mask(input logic [DATA_BYTE_WD-1:0] k);
    lane_mask = '0;
    for (int unsigned i = 0; i < DATA_BYTE_WD; i++)
      lane_mask[8*i +: 8] = {8{k[i]}};
  endfunction

  always_comb begin
    w_v = '0;
    for (int unsigned i = 0; i < DATA_BYTE_WD; i++)
      w_v = w_v + {{BYTE_CNT_WD{1'b0}}, keep_in[i]};
  end

  // Lanes outside keep_in are zeroed so stray data never leaks into output bytes.
  // A right shift by the full width (n=0) yields 0, so the new beat contributes nothing.
  always_comb begin
    w_din      = data_in & lane_mask(keep_in);
    w_shl_amt  = 32'(r_n) * 8;
    w_shr_amt  = DATA_WD - w_shl_amt;
    w_shl      = w_din << w_shl_amt;
    w_shr      = w_din >> w_shr_amt;
    w_v_gt_n   = w_v > {1'b0, r_n};
    w_tail_cnt = DATA_BYTE_WD - 32'(r_n) + 32'(w_v);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_hold       <= '0;
      r_hold_bytes <= '0;
      r_n          <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (valid_remove) begin
            r_n     <= byte_remove_cnt;
            r_state <= S_FIRST;
          end
        end
        S_FIRST, S_STREAM: begin
          if (valid_in && (r_state == S_FIRST || ready_out)) begin
            r_hold       <= w_shl;
            r_hold_bytes <= w_v - {1'b0, r_n};
            if (!last_in)      r_state <= S_STREAM;
            else if (w_v_gt_n) r_state <= S_FLUSH;
            else               r_state <= S_IDLE;
          end
        end
        S_FLUSH: begin
          if (ready_out) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode the state directly so STREAM handshakes pass through with
  // no added latency; holding rst_n low forces them all inactive.
  always_comb begin
    ready_remove = 1'b0;
    ready_in     = 1'b0;
    valid_out    = 1'b0;
    keep_out     = '0;
    last_out     = 1'b0;
    w_data       = '0;
    if (rst_n) begin
      case (r_state)
        S_IDLE:  ready_remove = 1'b1;
        S_FIRST: ready_in     = 1'b1;
        S_STREAM: begin
          valid_out = valid_in;
          ready_in  = ready_out;
          w_data    = r_hold | w_shr;
          if (last_in && !w_v_gt_n) begin
            keep_out = top_keep(w_tail_cnt);
            last_out = 1'b1;
          end else begin
            keep_out = '1;
          end
        end
        S_FLUSH: begin
          valid_out = 1'b1;
          w_data    = r_hold;
          keep_out  = top_keep(32'(r_hold_bytes));
          last_out  = 1'b1;
        end
        default: ;
      endcase
    end
    data_out = w_data & lane_mask(keep_out);
  end

endmodule

// File: tb/tb_axi_stream_remove_header.sv
module tb_axi_stream_remove_header;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic [31:0] data_in;
  logic [3:0]  keep_in;
  logic        last_in;
  logic        ready_in;
  logic        valid_out;
  logic [31:0] data_out;
  logic [3:0]  keep_out;
  logic        last_out;
  logic        ready_out;
  logic        valid_remove;
  logic [1:0]  byte_remove_cnt;
  logic        ready_remove;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned vcount   = 0;
  logic [36:0] obs_q[$];
  logic [36:0] exp_q[$];

  always #5 clk = ~clk;

  axi_stream_remove_header #(.DATA_WD(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in),
    .ready_in(ready_in),
    .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out),
    .ready_out(ready_out),
    .valid_remove(valid_remove), .byte_remove_cnt(byte_remove_cnt), .ready_remove(ready_remove)
  );

  // Output monitor: records every accepted output beat as {last, keep, data}.
  always @(negedge clk) begin
    if (rst_n && valid_out) begin
      vcount++;
      if (ready_out) obs_q.push_back({last_out, keep_out, data_out});
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic compare_outputs(input string tag);
    check({tag, "_cnt"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < obs_q.size()) check($sformatf("%s_b%0d", tag, i), 64'(obs_q[i]), 64'(exp_q[i]));
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] n);
    int unsigned t = 0;
    valid_remove = 1'b1;
    byte_remove_cnt = n;
    @(negedge clk);
    while (!ready_remove && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) check("cmd_timeout", 64'(ready_remove), 64'd1);
    @(posedge clk); #1;
    valid_remove = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    int unsigned t = 0;
    valid_in = 1'b1; data_in = d; keep_in = k; last_in = l;
    @(negedge clk);
    while (!ready_in && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) check("beat_timeout", 64'(ready_in), 64'd1);
    @(posedge clk); #1;
    valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned v0;
    rst_n = 1'b0; valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
    ready_out = 1'b1; valid_remove = 1'b0; byte_remove_cnt = '0;

    // Reset
    @(negedge clk);
    check("rst_valid_out", 64'(valid_out), 64'd0);
    check("rst_ready_in", 64'(ready_in), 64'd0);
    check("rst_ready_remove", 64'(ready_remove), 64'd0);
    check("rst_keep_out", 64'(keep_out), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready_remove", 64'(ready_remove), 64'd1);
    check("idle_data_out", 64'(data_out), 64'd0);
    check("idle_last_out", 64'(last_out), 64'd0);
    @(posedge clk); #1;

    // 1: n=0 pass-through
    send_cmd(2'd0);
    send_beat(32'h01020304, 4'b1111, 1'b0);
    send_beat(32'h05060708, 4'b1111, 1'b0);
    send_beat(32'h090A0000, 4'b1100, 1'b1);
    idle(4);
    exp_q.push_back({1'b0, 4'b1111, 32'h01020304});
    exp_q.push_back({1'b0, 4'b1111, 32'h05060708});
    exp_q.push_back({1'b1, 4'b1100, 32'h090A0000});
    compare_outputs("t1");

    // 2: n=1, trailing bytes go out from FLUSH
    send_cmd(2'd1);
    send_beat(32'hAABBCCDD, 4'b1111, 1'b0);
    send_beat(32'h11223344, 4'b1111, 1'b1);
    idle(4);
    exp_q.push_back({1'b0, 4'b1111, 32'hBBCCDD11});
    exp_q.push_back({1'b1, 4'b1110, 32'h22334400});
    compare_outputs("t2");

    // 3: n=2, last beat fits into a single output beat
    send_cmd(2'd2);
    send_beat(32'hAABBCCDD, 4'b1111, 1'b0);
    send_beat(32'h11220000, 4'b1100, 1'b1);
    @(negedge clk);
    check("t3_ready_remove", 64'(ready_remove), 64'd1);
    idle(2);
    exp_q.push_back({1'b1, 4'b1111, 32'hCCDD1122});
    compare_outputs("t3");

    // 4: n=3, whole packet is header
    v0 = vcount;
    send_cmd(2'd3);
    send_beat(32'hAABBCC00, 4'b1110, 1'b1);
    @(negedge clk);
    check("t4_ready_remove", 64'(ready_remove), 64'd1);
    idle(3);
    check("t4_no_valid", 64'(vcount - v0), 64'd0);
    compare_outputs("t4");

    // 5: back-pressure in STREAM
    send_cmd(2'd1);
    send_beat(32'hAABBCCDD, 4'b1111, 1'b0);
    valid_in = 1'b1; data_in = 32'h11223344; keep_in = 4'b1111; last_in = 1'b0;
    ready_out = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("t5_stall_rdy%0d", c), 64'(ready_in), 64'd0);
      check($sformatf("t5_stall_vld%0d", c), 64'(valid_out), 64'd1);
      check($sformatf("t5_stall_dk%0d", c), 64'({keep_out, last_out, data_out}),
            64'({4'b1111, 1'b0, 32'hBBCCDD11}));
      @(posedge clk); #1;
    end
    ready_out = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    send_beat(32'h55667788, 4'b1111, 1'b1);
    idle(4);
    exp_q.push_back({1'b0, 4'b1111, 32'hBBCCDD11});
    exp_q.push_back({1'b0, 4'b1111, 32'h22334455});
    exp_q.push_back({1'b1, 4'b1110, 32'h66778800});
    compare_outputs("t5");

    // 6: reset mid-packet, then a clean n=2 packet
    send_cmd(2'd1);
    send_beat(32'hAABBCCDD, 4'b1111, 1'b0);
    send_beat(32'h11223344, 4'b1111, 1'b0);
    valid_in = 1'b1; data_in = 32'h99887766; keep_in = 4'b1111; last_in = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    valid_in = 1'b0; data_in = '0; keep_in = '0;
    @(negedge clk);
    check("t6_valid_out", 64'(valid_out), 64'd0);
    check("t6_ready_in", 64'(ready_in), 64'd0);
    @(posedge clk); #1;
    obs_q.delete();
    send_cmd(2'd2);
    send_beat(32'h01020304, 4'b1111, 1'b0);
    send_beat(32'h05060708, 4'b1111, 1'b1);
    idle(4);
    exp_q.push_back({1'b0, 4'b1111, 32'h03040506});
    exp_q.push_back({1'b1, 4'b1100, 32'h07080000});
    compare_outputs("t6");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
